clint: RTL and testbench
========================

# clint

Core-local interruptor: a memory-mapped timer/software-interrupt responder on the data bus, sitting on the dbus side opposite the core's memory stage. It services the core's `dbus_req_t` loads and stores with a fixed-latency `dbus_resp_t` handshake, keeps the `msip`, `mtimecmp` and `mtime` registers, and drives the core's `trint` and `swint` inputs. `exint` is not produced here.

## Interface
Parameters:
- `BASE_ADDR`, default `64'h0200_0000`: base of the 64 KiB CLINT window.
- `LATENCY`, default `1`: cycles from request acceptance to `data_ok`; legal range 1..15.
- `TICK_DIV`, default `1`: `mtime` increments once every `TICK_DIV` clocks; legal range 1..65535.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `dreq`, input, `dbus_req_t`: fields `valid`, `addr`[63:0], `size`, `strobe`[7:0], `data`[63:0]. `strobe` and `data` are byte-lane aligned to `addr[2:0]`. A non-zero `strobe` means a write.
- `dresp`, output, `dbus_resp_t`: fields `addr_ok`, `data_ok`, `data`[63:0].
- `trint`, output, 1: machine timer interrupt pending.
- `swint`, output, 1: machine software interrupt pending.

## Operation
- Offset is `dreq.addr - BASE_ADDR`. The dword is selected by `offset[15:3]`.
  - `0x0000`: `msip`, bit 0 only. Reads return `{63'b0, msip}`.
  - `0x4000`: `mtimecmp`, 64 bits.
  - `0xBFF8`: `mtime`, 64 bits.
- Any other offset, or any address outside `[BASE_ADDR, BASE_ADDR+0x10000)`:
  - reads return 0, writes are dropped;
  - the request still completes normally. No error path exists.
- The FSM has three states: IDLE, BUSY, RESP.
  - IDLE: when `dreq.valid` is high, latch `addr`, `strobe` and `data`, and load the latency counter with `LATENCY-1`. Go to RESP if `LATENCY==1`, else go to BUSY.
  - BUSY: decrement the counter. Go to RESP when the counter reaches 1.
  - RESP: assert `addr_ok` and `data_ok` for exactly this one cycle, with `data` valid. Then go to IDLE.
- The response uses the latched request. `dreq` changes or `dreq.valid` dropping during BUSY or RESP are ignored.
- A `dreq.valid` seen in the cycle after RESP is a new request.
- Writes merge per byte lane: `reg[8i+7:8i] <= data[8i+7:8i]` where `strobe[i]` is set.
  - The write commits on the clock edge that ends the RESP cycle.
  - Read data in RESP is the register value before that commit.
  - For `msip`, only lane 0 bit 0 is stored. Other bits are discarded.
- `mtime` is a 64-bit counter driven by a prescaler.
  - The prescaler counts 0..`TICK_DIV-1`. When it wraps, `mtime` increments.
  - `mtime` wraps from all-ones to 0.
  - An `mtime` write commit in the same cycle as a tick wins: masked lanes take the written value, with no increment that cycle.
  - A write does not reset the prescaler.
- `trint` is registered: `trint <= (mtime >= mtimecmp)`, unsigned compare on the current register values.
- `swint` is registered: `swint <= msip`.

## Timing
- Reset (asynchronous, `reset==0`):
  - FSM goes to IDLE, counter is 0, prescaler is 0.
  - `mtime=0`, `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF`, `msip=0`.
  - `dresp` is all zero, `trint=0`, `swint=0`.
- Reset asserted mid-transaction aborts it: no response is issued and no write commits.
- Request accepted in IDLE at cycle T gives `addr_ok=data_ok=1` at cycle T+`LATENCY`. Back-to-back throughput is one request per `LATENCY+1` cycles.
- `dresp.addr_ok`, `dresp.data_ok` and `dresp.data` are 0 in every cycle other than RESP.
- Interrupt latency:
  - `swint` rises 2 cycles after the RESP cycle of an `msip=1` write.
  - `trint` rises 1 cycle after the first cycle where `mtime >= mtimecmp`.
- Outputs are registered or derived only from FSM state. There is no combinational path from `dreq` to `dresp`.

## Test plan
- **Reset values.** Hold `reset=0` for 3 cycles, then release. Required: `dresp==0`, `trint=0`, `swint=0`. A read at `BASE+0x4000` returns `64'hFFFF_FFFF_FFFF_FFFF`.
- **Latency and msip.** With `LATENCY=3`, write `strobe=8'h0F`, `data=1` to `BASE+0x0`. Required: `data_ok` exactly 3 cycles after acceptance, for one cycle, and `swint=1` 2 cycles after RESP. A following read returns 1.
- **Timer fire.** With `TICK_DIV=1`, write `mtimecmp=20` and `mtime=0`. Required: `trint` rises exactly one cycle after `mtime` reads 20. Writing `mtimecmp=64'hFFFF_FFFF_FFFF_FFFF` clears `trint` one cycle after commit.
- **Partial write and write-vs-tick.** Write `mtime` with `strobe=8'hF0`, `data=64'h0000_0005_0000_0000` in a tick cycle. Required: upper half becomes 5, lower half keeps its pre-commit value, and there is no increment that cycle.
- **Wrap and prescale.** With `TICK_DIV=4`, write `mtime=64'hFFFF_FFFF_FFFF_FFFE`. Required: the value reaches 0 after 8 clocks, incrementing once per 4 cycles.
- **Unmapped and reset abort.**
  - Read `BASE+0x8000` and write `BASE+0x20000`. Required: both complete, the read returns 0, and no register changes.
  - Assert `reset` during BUSY. Required: no `data_ok` and the registers are at reset values.

Source files
------------

// File: rtl/clint.sv
// Core-local interruptor: memory-mapped msip / mtimecmp / mtime registers on
// the data bus, answering each request after a fixed latency and driving the
// core's timer and software interrupt inputs.

package clint_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

module clint
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       trint,
    output logic       swint
);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_strobe;

    logic [15:0] presc;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        msip;

    logic [63:0] offset;
    logic        in_window;
    logic [12:0] dword;
    logic        hit_msip;
    logic        hit_cmp;
    logic        hit_time;
    logic        commit;
    logic [63:0] rdata;

    // The transfer size is implied by the strobe lanes, so it is not decoded.
    logic unused_size;
    assign unused_size = ^dreq.size;

    // Byte-lane merge of write data into an existing register value.
    function automatic logic [63:0] merge(input logic [63:0] old_val,
                                          input logic [63:0] wdata,
                                          input logic [7:0]  strobe);
        logic [63:0] res;
        res = old_val;
        for (int i = 0; i < 8; i++)
            if (strobe[i]) res[8*i +: 8] = wdata[8*i +: 8];
        return res;
    endfunction

    // Decode works on the latched request only; an address below the base
    // wraps to a huge offset and therefore falls outside the window.
    assign offset    = req_addr - BASE_ADDR;
    assign in_window = (offset < 64'h0000_0000_0001_0000);
    assign dword     = offset[15:3];
    assign hit_msip  = in_window && (dword == 13'h0000);
    assign hit_cmp   = in_window && (dword == 13'h0800);
    assign hit_time  = in_window && (dword == 13'h17FF);
    // Writes commit on the edge that closes the response cycle.
    assign commit    = (state == RESP) && (req_strobe != 8'h00);
    assign tick      = (presc == 16'(TICK_DIV - 1));

    // FSM state register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // FSM next-state logic.
    // NOTE: the default assignment up front keeps this block free of latches.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (dreq.valid) state_next = (LATENCY == 1) ? RESP : BUSY;
            BUSY:    if (cnt == 4'd1) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response outputs depend only on the FSM state and the register file.
    always_comb begin
        dresp = '0;
        if (state == RESP) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = rdata;
        end
    end

    // Read mux: unmapped offsets read as zero.
    always_comb begin
        rdata = '0;
        if (hit_msip)      rdata = {63'b0, msip};
        else if (hit_cmp)  rdata = mtimecmp;
        else if (hit_time) rdata = mtime;
    end

    // Request capture and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            req_addr   <= '0;
            req_data   <= '0;
            req_strobe <= '0;
        end else if (state == IDLE && dreq.valid) begin
            cnt        <= 4'(LATENCY - 1);
            req_addr   <= dreq.addr;
            req_data   <= dreq.data;
            req_strobe <= dreq.strobe;
        end else if (state == BUSY) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Prescaler and mtime; a write commit overrides a coincident tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc <= '0;
            mtime <= '0;
        end else begin
            presc <= tick ? 16'd0 : presc + 16'd1;
            if (commit && hit_time) mtime <= merge(mtime, req_data, req_strobe);
            else if (tick)          mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp and msip writes; msip keeps only lane 0 bit 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mtimecmp <= '1;
            msip     <= 1'b0;
        end else begin
            if (commit && hit_cmp) mtimecmp <= merge(mtimecmp, req_data, req_strobe);
            if (commit && hit_msip && req_strobe[0]) msip <= req_data[0];
        end
    end

    // Registered interrupt outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trint <= 1'b0;
            swint <= 1'b0;
        end else begin
            trint <= (mtime >= mtimecmp);
            swint <= msip;
        end
    end

endmodule

// File: tb/tb_clint.sv
// Scoreboard bench for clint: u_dut0 (LATENCY=3, TICK_DIV=1) and
// u_dut1 (LATENCY=1, TICK_DIV=4). The driver queues expected responses; the
// monitor pops them when data_ok appears and performs all comparisons.
`timescale 1ns/1ps
module tb_clint;
    import clint_pkg::*;

    localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam int LAT0 = 3;
    localparam int DIV0 = 1;
    localparam int LAT1 = 1;
    localparam int DIV1 = 4;

    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq0, dreq1;
    dbus_resp_t dresp0, dresp1;
    logic       trint0, swint0, trint1, swint1;

    int checks = 0;
    int errors = 0;
    int edge_n;

    // Expected responses (data, edge count of the response cycle).
    logic [63:0] exp_d0[$], exp_d1[$];
    int          exp_e0[$], exp_e1[$];
    // Direct observations posted by the driver for the monitor to compare.
    string       cn_q[$];
    logic [63:0] ca_q[$], ce_q[$];

    // mtime model: value base_v at edge base_e, plus ticks since then.
    logic [63:0] base_v[2];
    int          base_e[2];

    always #5 clk = ~clk;

    clint #(.BASE_ADDR(BASE), .LATENCY(LAT0), .TICK_DIV(DIV0)) u_dut0 (
        .clk(clk), .reset(reset), .dreq(dreq0), .dresp(dresp0),
        .trint(trint0), .swint(swint0));

    clint #(.BASE_ADDR(BASE), .LATENCY(LAT1), .TICK_DIV(DIV1)) u_dut1 (
        .clk(clk), .reset(reset), .dreq(dreq1), .dresp(dresp1),
        .trint(trint1), .swint(swint1));

    // Clock edges since reset release; a tick lands on every edge n with n % div == 0.
    always @(posedge clk or negedge reset) begin
        if (!reset) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] w,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = o;
        for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = w[8*i +: 8];
        return r;
    endfunction

    function automatic logic [63:0] mtime_at(input int u, input int c);
        int div;
        div = (u == 0) ? DIV0 : DIV1;
        return base_v[u] + 64'(c / div - base_e[u] / div);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic post(input string name, input logic [63:0] act, input logic [63:0] exp);
        cn_q.push_back(name);
        ca_q.push_back(act);
        ce_q.push_back(exp);
    endtask

    task automatic mon(input int u, input dbus_resp_t r);
        logic [63:0] ed;
        int          ee;
        int          pending;
        if (r.data_ok) begin
            pending = (u == 0) ? exp_d0.size() : exp_d1.size();
            if (pending == 0) begin
                check($sformatf("u%0d_unexpected_resp", u), 64'd1, 64'd0);
            end else begin
                if (u == 0) begin ed = exp_d0.pop_front(); ee = exp_e0.pop_front(); end
                else        begin ed = exp_d1.pop_front(); ee = exp_e1.pop_front(); end
                check($sformatf("u%0d_rdata", u), r.data, ed);
                check($sformatf("u%0d_resp_cycle", u), 64'(edge_n), 64'(ee));
                check($sformatf("u%0d_addr_ok", u), {63'b0, r.addr_ok}, 64'd1);
            end
        end else begin
            check($sformatf("u%0d_dresp_quiet", u), r.data | {63'b0, r.addr_ok}, 64'd0);
        end
    endtask

    // Monitor: compares responses against the scoreboard and drains posted checks.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon(0, dresp0);
            mon(1, dresp1);
        end
        while (cn_q.size() > 0) check(cn_q.pop_front(), ca_q.pop_front(), ce_q.pop_front());
    end

    // One bus transaction; called and returning at #1 after a rising edge.
    task automatic bus(input int u, input logic [63:0] addr, input logic [7:0] strobe,
                       input logic [63:0] data, input logic [63:0] exp, input bit is_time);
        int          lat;
        int          resp_e;
        logic [63:0] e;
        dbus_req_t   r;
        lat    = (u == 0) ? LAT0 : LAT1;
        resp_e = edge_n + lat;
        e      = is_time ? mtime_at(u, resp_e) : exp;
        if (u == 0) begin exp_d0.push_back(e); exp_e0.push_back(resp_e); end
        else        begin exp_d1.push_back(e); exp_e1.push_back(resp_e); end
        r = '0;
        r.valid  = 1'b1;
        r.addr   = addr;
        r.size   = 3'd3;
        r.strobe = strobe;
        r.data   = data;
        if (u == 0) dreq0 = r; else dreq1 = r;
        @(posedge clk); #1;
        if (u == 0) dreq0 = '0; else dreq1 = '0;
        repeat (lat) @(posedge clk);
        #1;
        if (is_time && strobe != 8'h00) begin
            base_v[u] = merge(mtime_at(u, edge_n - 1), data, strobe);
            base_e[u] = edge_n;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            base_v[u] = '0;
            base_e[u] = 0;
        end
    endtask

    initial begin
        reset = 1'b0;
        dreq0 = '0;
        dreq1 = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Reset values.
        post("reset_dresp0", dresp0.data | {62'b0, dresp0.addr_ok, dresp0.data_ok}, 64'd0);
        post("reset_trint0", {63'b0, trint0}, 64'd0);
        post("reset_swint0", {63'b0, swint0}, 64'd0);
        post("reset_trint1", {63'b0, trint1}, 64'd0);
        post("reset_swint1", {63'b0, swint1}, 64'd0);
        bus(0, BASE + 64'h4000, 8'h00, 64'd0, ONES, 1'b0);
        bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, 64'd0, 1'b1);

        // Unmapped and out-of-window accesses, including aliases of real registers.
        bus(0, BASE + 64'h8000,  8'h00, 64'd0, 64'd0, 1'b0);
        bus(0, BASE + 64'h2_0000, 8'hFF, ONES, 64'd0, 1'b0);
        bus(0, BASE + 64'h1_BFF8, 8'hFF, ONES, 64'd0, 1'b0);
        bus(0, BASE - 64'hC000,  8'h00, 64'd0, 64'd0, 1'b0);
        bus(0, BASE,             8'h00, 64'd0, 64'd0, 1'b0);
        bus(0, BASE + 64'h4000,  8'h00, 64'd0, ONES, 1'b0);
        bus(0, BASE + 64'hBFF8,  8'h00, 64'd0, 64'd0, 1'b1);
        post("unmapped_swint0", {63'b0, swint0}, 64'd0);

        // msip write, latency 3, swint two cycles after the response cycle.
        bus(0, BASE, 8'h0F, 64'd1, 64'd0, 1'b0);
        post("swint_plus1", {63'b0, swint0}, 64'd0);
        @(posedge clk); #1;
        post("swint_plus2", {63'b0, swint0}, 64'd1);
        bus(0, BASE, 8'h00, 64'd0, 64'd1, 1'b0);
        bus(0, BASE, 8'hFE, ONES, 64'd1, 1'b0);
        bus(0, BASE, 8'h00, 64'd0, 64'd1, 1'b0);
        bus(0, BASE, 8'h01, 64'h0000_0000_0000_00FE, 64'd1, 1'b0);
        bus(0, BASE, 8'h00, 64'd0, 64'd0, 1'b0);

        // Timer fire at mtime == 20, then clear by raising mtimecmp.
        bus(0, BASE + 64'hBFF8, 8'hFF, 64'd0, 64'd0, 1'b1);
        bus(0, BASE + 64'h4000, 8'hFF, 64'd20, ONES, 1'b0);
        for (int i = 0; i < 100 && mtime_at(0, edge_n) != 64'd20; i++) begin
            @(posedge clk); #1;
        end
        post("trint_at_match", {63'b0, trint0}, 64'd0);
        @(posedge clk); #1;
        post("trint_after_match", {63'b0, trint0}, 64'd1);
        bus(0, BASE + 64'h4000, 8'hFF, ONES, 64'd20, 1'b0);
        post("trint_commit_cycle", {63'b0, trint0}, 64'd1);
        @(posedge clk); #1;
        post("trint_cleared", {63'b0, trint0}, 64'd0);

        // Upper-half write to mtime on a tick cycle; lower half keeps its value.
        bus(0, BASE + 64'hBFF8, 8'hF0, 64'h0000_0005_0000_0000, 64'd0, 1'b1);
        bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, 64'd0, 1'b1);
        post("partial_upper_model", base_v[0][63:32], 64'd5);

        // Wrap with prescale 4: align so the commit edge is itself a tick edge.
        for (int i = 0; i < 8 && (edge_n % 4) != 2; i++) begin
            @(posedge clk); #1;
        end
        bus(1, BASE + 64'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 1'b1);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, ONES, 1'b0);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, ONES, 1'b0);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, 64'd0, 1'b0);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, 64'd0, 1'b0);

        // Reset during BUSY aborts the mtimecmp write; no response may appear.
        bus(0, BASE, 8'h01, 64'd1, 64'd0, 1'b0);
        dreq0        = '0;
        dreq0.valid  = 1'b1;
        dreq0.addr   = BASE + 64'h4000;
        dreq0.size   = 3'd3;
        dreq0.strobe = 8'hFF;
        dreq0.data   = 64'd5;
        @(posedge clk); #1;
        dreq0 = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        model_reset();
        post("abort_dresp0", dresp0.data | {62'b0, dresp0.addr_ok, dresp0.data_ok}, 64'd0);
        post("abort_trint0", {63'b0, trint0}, 64'd0);
        post("abort_swint0", {63'b0, swint0}, 64'd0);
        bus(0, BASE,            8'h00, 64'd0, 64'd0, 1'b0);
        bus(0, BASE + 64'h4000, 8'h00, 64'd0, ONES, 1'b0);
        bus(0, BASE + 64'hBFF8, 8'h00, 64'd0, 64'd0, 1'b1);
        bus(1, BASE + 64'hBFF8, 8'h00, 64'd0, 64'd0, 1'b1);

        repeat (4) @(posedge clk);
        #1;
        post("scoreboard_drained", 64'(exp_d0.size() + exp_d1.size()), 64'd0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
